// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
//   state_e   : responder FSM states
//   WORD_W    : instruction word width
//   WAIT_MAX  : largest legal WAIT_CYCLES value
package inst_mem_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned WAIT_MAX = 15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/inst_mem_resp_if.sv
// Fetch request / response bundle between the PC stage and the responder.
//   master : PC stage (drives inst_ce, addr, resp_ready)
//   slave  : responder (drives req_ready, inst, resp_valid, err)
interface inst_mem_resp_if;
    import inst_mem_pkg::*;

    logic              inst_ce;
    logic [WORD_W-1:0] addr;
    logic              req_ready;
    logic [WORD_W-1:0] inst;
    logic              resp_valid;
    logic              resp_ready;
    logic              err;

    modport master (
        output inst_ce, addr, resp_ready,
        input  req_ready, inst, resp_valid, err
    );

    modport slave (
        input  inst_ce, addr, resp_ready,
        output req_ready, inst, resp_valid, err
    );

endinterface

// File: rtl/inst_mem_array.sv
// Instruction storage: one write port, one synchronous read port, write-first.
//   clk, rst      : clock, async active-low reset (clears only the read register)
//   we/waddr/wdata: write port
//   re/raddr      : read strobe and word index; rdata updates only on re
//   rzero         : with re, load zero into rdata instead of the array word
module inst_mem_array
    import inst_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic              rzero,
    input  logic [IDX_W-1:0]  raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register; a same-cycle write to the read word is forwarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            if (rzero) begin
                rdata <= '0;
            end else if (we && (waddr == raddr)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction fetch responder: accepts one fetch in IDLE, waits WAIT_CYCLES,
// then presents the word until the consumer takes it.
//   clk, rst                  : clock, async active-low reset
//   load_en/load_addr/load_data: preload write port (usable in any state)
//   bus (slave)               : fetch request/response handshake
// Optional macro INST_MEM_FAULT_CHECK_EN: flag misaligned/out-of-range fetches
// on err (inst forced to 0) and drop out-of-range loads. Without it, err is 0
// and addresses wrap modulo DEPTH_WORDS.
module inst_mem_resp
    import inst_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [WORD_W-1:0] load_addr,
    input  logic [WORD_W-1:0] load_data,
    inst_mem_resp_if.slave    bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] addr_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic              err_q;
    logic [WORD_W-1:0] rdata;

    logic [WORD_W-1:0] rd_addr;
    logic              enter_resp;
    logic              rd_fault;
    logic              ld_ok;
    logic              unused_bits;

    // With zero wait states the read happens on the accept edge itself,
    // before addr_q holds the address, so read straight from the bus.
    assign rd_addr    = (state == S_IDLE) ? bus.addr : addr_q;
    assign enter_resp = ((state == S_IDLE) && bus.inst_ce && (WAIT_CYCLES == 0))
                     || ((state == S_WAIT) && (cnt == '0));

`ifdef INST_MEM_FAULT_CHECK_EN
    assign rd_fault    = (rd_addr[1:0] != 2'b00) || (|rd_addr[WORD_W-1:IDX_W+2]);
    assign ld_ok       = ~|load_addr[WORD_W-1:IDX_W+2];
    assign unused_bits = ^load_addr[1:0];
`else
    assign rd_fault    = 1'b0;
    assign ld_ok       = 1'b1;
    assign unused_bits = ^{rd_addr[WORD_W-1:IDX_W+2], rd_addr[1:0],
                           load_addr[WORD_W-1:IDX_W+2], load_addr[1:0]};
`endif

    // Fetch FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.inst_ce) begin
                        addr_q      <= bus.addr;
                        req_ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state        <= S_RESP;
                            resp_valid_q <= 1'b1;
                            err_q        <= rd_fault;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state        <= S_RESP;
                        resp_valid_q <= 1'b1;
                        err_q        <= rd_fault;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        state        <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        err_q        <= 1'b0;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    err_q        <= 1'b0;
                end
            endcase
        end
    end

    inst_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (load_en && ld_ok),
        .waddr (load_addr[IDX_W+1:2]),
        .wdata (load_data),
        .re    (enter_resp),
        .rzero (rd_fault),
        .raddr (rd_addr[IDX_W+1:2]),
        .rdata (rdata)
    );

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.inst       = rdata;
    assign bus.err        = err_q;

endmodule

// File: doc/inst_mem_resp.md
INST_MEM_RESP -- requirements
Module: inst_mem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit instruction words held (power of two).
REQ-002 Parameter WAIT_CYCLES, default 1, extra wait states per fetch, legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 inst_ce  input  1  fetch request valid from the PC stage.
REQ-006 addr  input  32  byte address of the requested instruction.
REQ-007 req_ready  output  1  responder can accept a fetch this cycle.
REQ-008 inst  output  32  fetched instruction word.
REQ-009 resp_valid  output  1  inst is valid.
REQ-010 resp_ready  input  1  consumer accepts the response.
REQ-011 load_en  input  1  preload write strobe.
REQ-012 load_addr  input  32  preload byte address.
REQ-013 load_data  input  32  preload word.
REQ-014 err  output  1  fetch fault flag, valid with resp_valid (macro-dependent, see Configuration).

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 IDLE: req_ready=1, resp_valid=0; inst_ce=1 at a rising edge is a fetch accept, capturing addr.
REQ-017 On accept: WAIT_CYCLES=0 -> RESP next cycle; otherwise -> WAIT with the counter loaded to WAIT_CYCLES-1.
REQ-018 WAIT: counter decrements each cycle; at 0 -> RESP.
REQ-019 resp_valid asserts exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 Word index = captured addr[log2(DEPTH_WORDS)+1:2]; the array is read on the edge entering RESP, and inst is registered then.
REQ-021 RESP: resp_valid=1; inst and err are held stable until resp_ready=1; on resp_ready -> IDLE.
REQ-022 req_ready=0 in WAIT and RESP; inst_ce in those states is ignored, not queued.
REQ-023 Throughput: one fetch per WAIT_CYCLES+2 cycles at best.
REQ-024 load_en writes load_data to word load_addr[log2(DEPTH_WORDS)+1:2] in any state.
REQ-025 Simultaneous load and the RESP-entry read of the same word: the read returns the newly loaded data (write-first).
REQ-026 A load during WAIT to the pending word is reflected in inst.

Reset
REQ-027 Reset asserted (rst=0) forces IDLE asynchronously, with resp_valid=0, inst=0, err=0, and counter=0.
REQ-028 Reset mid-fetch drops the pending fetch with no response.
REQ-029 Array contents are not cleared by reset.
REQ-030 req_ready=1 while in reset.

Configuration
REQ-031 Macro INST_MEM_FAULT_CHECK_EN defined: err=1 in RESP when addr[1:0]!=0 or addr>=DEPTH_WORDS*4; inst=0 for a faulting fetch; load writes to out-of-range addresses are dropped.
REQ-032 Macro undefined: err tied 0; addr[1:0] ignored; out-of-range addresses wrap modulo DEPTH_WORDS for both fetch and load.

Structure
REQ-033 Package inst_mem_pkg holds the state enum, WORD_W=32, and the WAIT_CYCLES range limit.
REQ-034 Storage lives in sub-module inst_mem_array: a 1 write port, 1 read port synchronous array with write-first semantics.
REQ-035 The FSM, wait counter and fault logic stay in inst_mem_resp.

Verification
REQ-036 Preload word 0=0x20080005, WAIT_CYCLES=1, fetch addr=0 with resp_ready=1 -> resp_valid on the 2nd edge after accept, inst=0x20080005, then IDLE.
REQ-037 WAIT_CYCLES=0, resp_ready=0 for 5 cycles -> resp_valid and inst held for 5 cycles, req_ready=0 throughout.
REQ-038 Fetch addr=0x8 pending in WAIT, load_addr=0x8 load_data=0xDEADBEEF -> inst=0xDEADBEEF.
REQ-039 Reset pulsed low during WAIT -> resp_valid never rises, req_ready=1 after reset, earlier preloaded words still readable.
REQ-040 Macro defined: fetch addr=0x2 -> err=1, inst=0; fetch addr=0x400 (DEPTH_WORDS=256) -> err=1.
REQ-041 Macro undefined: fetch addr=0x404 -> inst equals word 1 content, err=0.
